fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Write-side arbiter and sequencer for the multi-port `fifo`. It shares the FIFO's WRITE write ports among REQ independent valid/ready requesters with round-robin fairness. It tracks FIFO occupancy with a credit counter so that no write is ever issued into a full queue. It also sequences queue flushes through a small state machine. It sits between the producer units and one `fifo` instance configured with ACT=`Low` and BUF_EXT=`Disable`.

## Interface
- DATA, 64, payload width; must equal the FIFO's DATA
- DEPTH, 32, FIFO depth; must equal the FIFO's DEPTH
- REQ, 4, number of requesters (≥1)
- WRITE, 2, FIFO write ports (≥1, ≤REQ)
- READ, 2, FIFO read ports
- CNT = $clog2(DEPTH+1), derived occupancy width
- clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- req_v  in  REQ  request valid, active high
- req_d  in  REQ×DATA  request payload
- req_rdy  out  REQ  request accepted this cycle, active high
- flush_req  in  1  flush request, active high, sampled in IDLE only
- flush_done  out  1  one-cycle pulse at flush completion
- fifo_flush_  out  1  to FIFO flush_, active low
- fifo_we_  out  WRITE  to FIFO we, active low
- fifo_wd  out  WRITE×DATA  to FIFO wd
- fifo_re_  in  READ  copy of the consumer's FIFO re, active low
- fifo_v  in  READ  FIFO v
- count  out  CNT  tracked occupancy
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation
- State: count (CNT bits), rr_ptr ($clog2(REQ) bits, at least 1), fsm ∈ {IDLE, FLUSH, WAIT}.
- free = DEPTH − count. Grants use only the registered count; same-cycle reads do not add credit.
- Grant (IDLE only):
  - Scan requesters in order rr_ptr, rr_ptr+1, … modulo REQ.
  - Grant the first G requesters that have req_v=1, where G = min(WRITE, free, number of valid requesters).
  - The k-th granted requester (k=0..G−1, in scan order) drives fifo_wd[k] and fifo_we_[k]=0.
  - Ports G..WRITE−1 are driven with fifo_we_=1 and fifo_wd=0. Ports are always packed from port 0 upward.
  - req_rdy[i]=1 exactly for granted i. req_rdy may depend combinationally on req_v; req_v must not depend on req_rdy.
  - A transfer occurs when req_v & req_rdy are both high.
- rr_ptr update: if G>0, rr_ptr ← (index of last granted requester + 1) mod REQ; if G=0, rr_ptr is unchanged.
- Pops: npop = popcount(~fifo_re_ & fifo_v).
- Count update:
  - IDLE: count ← count + G − npop, clamped at 0.
  - FLUSH: count ← 0.
  - WAIT: count ← count − npop, clamped at 0. The FIFO is already empty, so this evaluates to 0.
- FSM:
  - IDLE: if flush_req=1 → FLUSH. Grants that cycle proceed normally; those writes are destroyed by the flush.
  - FLUSH (1 cycle): fifo_flush_=0, all req_rdy=0, all fifo_we_=1 → WAIT.
  - WAIT (1 cycle): req_rdy=0, fifo_we_=1, flush_done=1 → IDLE.
  - flush_req is ignored in FLUSH and WAIT.
- Reset values: count=0, rr_ptr=0, fsm=IDLE, fifo_flush_=1, fifo_we_=all 1, fifo_wd=0, flush_done=0, empty=1, full=0.
- With req_v=0 after reset, req_rdy=0.
- Reset asserted mid-flush returns immediately to IDLE with the reset values above.

## Timing
- Accept-to-FIFO: a payload accepted in cycle t appears at fifo_wd in cycle t, is registered by the FIFO at edge t+1, and is visible on FIFO rd/v from t+1 (if ahead of queue).
- count reflects writes and pops of cycle t at t+1.
- A pop in cycle t frees credit for grants from t+1.
- flush_req high at t (IDLE) → fifo_flush_=0 at t+1 → flush_done=1 at t+2 → grants resume at t+3.
- count==DEPTH: all req_rdy=0.
- count==DEPTH−1 with WRITE=2 and two valid requesters: exactly one grant.
- rr_ptr wrap-around: REQ−1 is followed by 0.
- Simultaneous G writes and npop reads in one cycle: both are applied in the same count update.

## Test plan
- Reset, then req_v=4'b1111 with WRITE=2 and DEPTH=32 → cycle 1 grants req0→port0 and req1→port1, rr_ptr=2; cycle 2 grants req2 and req3, rr_ptr=0; count=4 after 2 cycles.
- Sparse requests: req_v=4'b1001 with rr_ptr=1 → req3→port0, req0→port1, fifo_we_=2'b00, rr_ptr=1.
- Fill: hold req_v=4'b0001 with no reads → count reaches 32, then full=1 and req_rdy=0. One pop (fifo_re_[0]=0, fifo_v[0]=1) → next cycle count=31 and req0 granted again; count returns to 32.
- Near-full: count=31, req_v=4'b0011 → exactly req_rdy=4'b0001 (given rr_ptr=0), fifo_we_=2'b10, count=32.
- Concurrent write and read: count=10, 2 grants and 2 pops in the same cycle → count stays 10.
- Flush: count=7, flush_req pulse at t → fifo_flush_=0 at t+1, req_rdy=0 at t+1 and t+2, flush_done=1 at t+2, count=0 at t+2, grants resume at t+3. A flush_req held through FLUSH/WAIT does not retrigger until back in IDLE.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester handshake, FIFO write/flush side and occupancy status of the write arbiter.
interface fifo_wr_arb_if #(
    parameter int DATA  = 64,
    parameter int DEPTH = 32,
    parameter int REQ   = 4,
    parameter int WRITE = 2,
    parameter int READ  = 2,
    parameter int CNT   = $clog2(DEPTH + 1)
);
    logic [REQ-1:0]              req_v;
    logic [REQ-1:0][DATA-1:0]    req_d;
    logic [REQ-1:0]              req_rdy;
    logic                        flush_req;
    logic                        flush_done;
    logic                        fifo_flush_;
    logic [WRITE-1:0]            fifo_we_;
    logic [WRITE-1:0][DATA-1:0]  fifo_wd;
    logic [READ-1:0]             fifo_re_;
    logic [READ-1:0]             fifo_v;
    logic [CNT-1:0]              count;
    logic                        empty;
    logic                        full;

    modport slave (
        input  req_v, req_d, flush_req, fifo_re_, fifo_v,
        output req_rdy, flush_done, fifo_flush_, fifo_we_, fifo_wd, count, empty, full
    );

    modport master (
        output req_v, req_d, flush_req, fifo_re_, fifo_v,
        input  req_rdy, flush_done, fifo_flush_, fifo_we_, fifo_wd, count, empty, full
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, credit-checked sharing of FIFO write ports among requesters, with flush sequencing.
module fifo_wr_arb #(
    parameter int DATA  = 64,
    parameter int DEPTH = 32,
    parameter int REQ   = 4,
    parameter int WRITE = 2,
    parameter int READ  = 2,
    parameter int CNT   = $clog2(DEPTH + 1)
) (
    input logic         clk,
    input logic         reset_,
    fifo_wr_arb_if.slave bus
);
    localparam int PW = REQ > 1 ? $clog2(REQ) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_t;

    state_t                     fsm, fsm_n;
    logic [CNT-1:0]             cnt, cnt_n, free;
    logic [PW-1:0]              rr, rr_n;
    logic [2*REQ-1:0]           v2, g2;
    logic [REQ-1:0]             rot_v, gnt_rot;
    logic [2*REQ*DATA-1:0]      d2;
    logic [REQ-1:0][DATA-1:0]   rot_d;
    int                         lim, g, last, npop, nxt, t;

    // Requesters are rotated so scan position 0 is rr; grants are rotated back afterwards.
    assign free        = CNT'(DEPTH) - cnt;
    assign v2          = {bus.req_v, bus.req_v} >> rr;
    assign rot_v       = v2[REQ-1:0];
    assign d2          = {bus.req_d, bus.req_d} >> (rr * DATA);
    assign rot_d       = d2[REQ*DATA-1:0];
    assign g2          = {gnt_rot, gnt_rot} << rr;
    assign bus.req_rdy = g2[2*REQ-1:REQ];

    assign bus.fifo_flush_ = fsm != FLUSH;
    assign bus.flush_done  = fsm == WAIT;
    assign bus.count       = cnt;
    assign bus.empty       = cnt == '0;
    assign bus.full        = cnt == CNT'(DEPTH);

    always_comb begin
        lim          = fsm != IDLE ? 0 : (int'(free) < WRITE ? int'(free) : WRITE);
        g            = 0;
        last         = 0;
        gnt_rot      = '0;
        bus.fifo_we_ = '1;
        bus.fifo_wd  = '0;
        for (int k = 0; k < REQ; k++) begin
            if (rot_v[k] && g < lim) begin
                gnt_rot[k] = 1'b1;
                for (int p = 0; p < WRITE; p++) begin
                    if (p == g) begin
                        bus.fifo_we_[p] = 1'b0;
                        bus.fifo_wd[p]  = rot_d[k];
                    end
                end
                last = k;
                g    = g + 1;
            end
        end
        npop = 0;
        for (int r = 0; r < READ; r++)
            npop = npop + int'(~bus.fifo_re_[r] & bus.fifo_v[r]);
        // Credit comes only from the registered count; pops free space from the next cycle.
        nxt   = fsm == FLUSH ? 0 : int'(cnt) + g - npop;
        cnt_n = nxt < 0 ? '0 : CNT'(nxt);
        t     = int'(rr) + last + 1;
        rr_n  = g == 0 ? rr : PW'(t >= REQ ? t - REQ : t);
    end

    always_comb begin
        fsm_n = fsm == IDLE ? (bus.flush_req ? FLUSH : IDLE) : fsm == FLUSH ? WAIT : IDLE;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fsm <= IDLE;
            cnt <= '0;
            rr  <= '0;
        end else begin
            fsm <= fsm_n;
            cnt <= cnt_n;
            rr  <= rr_n;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed vector table plus hand-written fill, credit and flush-reset sequences.
module tb_fifo_wr_arb;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wr_arb_if bus ();
    fifo_wr_arb dut (.clk(clk), .reset_(reset_), .bus(bus));

    typedef struct {
        logic [3:0] v;
        logic [1:0] re;
        logic [1:0] fv;
        logic       fr;
        logic [3:0] rdy;
        logic [1:0] we;
        int         s0;
        int         s1;
        logic       fl;
        logic       done;
        int         cnt;
    } vec_t;

    vec_t tv[17];

    function automatic logic [63:0] pay(input int i);
        return 64'hA5A5_0000_0000_0011 + 64'(i) * 64'h0001_0001;
    endfunction

    function automatic logic [63:0] src(input int s);
        return s < 4 ? pay(s) : 64'h0;
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [1:0] re, input logic [1:0] fv,
                                input logic fr, input logic [3:0] rdy, input logic [1:0] we,
                                input int s0, input int s1, input logic fl, input logic done,
                                input int cnt);
        vec_t e;
        e = '{v, re, fv, fr, rdy, we, s0, s1, fl, done, cnt};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [1:0] re, input logic [1:0] fv, input logic fr);
        bus.req_v     = v;
        bus.fifo_re_  = re;
        bus.fifo_v    = fv;
        bus.flush_req = fr;
    endtask

    task automatic chk_vec(input int i, input vec_t e);
        chk($sformatf("v%0d req_rdy", i), 64'(bus.req_rdy), 64'(e.rdy));
        chk($sformatf("v%0d fifo_we_", i), 64'(bus.fifo_we_), 64'(e.we));
        chk($sformatf("v%0d wd0", i), bus.fifo_wd[0], src(e.s0));
        chk($sformatf("v%0d wd1", i), bus.fifo_wd[1], src(e.s1));
        chk($sformatf("v%0d fifo_flush_", i), 64'(bus.fifo_flush_), 64'(e.fl));
        chk($sformatf("v%0d flush_done", i), 64'(bus.flush_done), 64'(e.done));
        chk($sformatf("v%0d count", i), 64'(bus.count), 64'(e.cnt));
        chk($sformatf("v%0d empty", i), 64'(bus.empty), 64'(e.cnt == 0));
        chk($sformatf("v%0d full", i), 64'(bus.full), 64'(e.cnt == 32));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus.req_d[i] = pay(i);
        drive(4'b0000, 2'b11, 2'b00, 1'b0);
        //            v        re     fv    fr   rdy      we     s0 s1 fl done cnt
        tv[0]  = mk(4'b1111, 2'b11, 2'b00, 0, 4'b0011, 2'b00, 0, 1, 1, 0, 0);
        tv[1]  = mk(4'b1111, 2'b11, 2'b00, 0, 4'b1100, 2'b00, 2, 3, 1, 0, 2);
        tv[2]  = mk(4'b0000, 2'b11, 2'b00, 0, 4'b0000, 2'b11, 4, 4, 1, 0, 4);
        tv[3]  = mk(4'b0001, 2'b11, 2'b00, 0, 4'b0001, 2'b10, 0, 4, 1, 0, 4);
        tv[4]  = mk(4'b1001, 2'b11, 2'b00, 0, 4'b1001, 2'b00, 3, 0, 1, 0, 5);
        tv[5]  = mk(4'b0010, 2'b11, 2'b00, 0, 4'b0010, 2'b10, 1, 4, 1, 0, 7);
        tv[6]  = mk(4'b0100, 2'b00, 2'b11, 0, 4'b0100, 2'b10, 2, 4, 1, 0, 8);
        tv[7]  = mk(4'b1001, 2'b11, 2'b00, 0, 4'b1001, 2'b00, 3, 0, 1, 0, 7);
        tv[8]  = mk(4'b0000, 2'b00, 2'b10, 0, 4'b0000, 2'b11, 4, 4, 1, 0, 9);
        tv[9]  = mk(4'b0110, 2'b00, 2'b11, 0, 4'b0110, 2'b00, 1, 2, 1, 0, 8);
        tv[10] = mk(4'b1000, 2'b11, 2'b00, 1, 4'b1000, 2'b10, 3, 4, 1, 0, 8);
        tv[11] = mk(4'b1111, 2'b11, 2'b00, 1, 4'b0000, 2'b11, 4, 4, 0, 0, 9);
        tv[12] = mk(4'b1111, 2'b11, 2'b00, 1, 4'b0000, 2'b11, 4, 4, 1, 1, 0);
        tv[13] = mk(4'b1111, 2'b11, 2'b00, 0, 4'b0011, 2'b00, 0, 1, 1, 0, 0);
        tv[14] = mk(4'b0000, 2'b00, 2'b11, 0, 4'b0000, 2'b11, 4, 4, 1, 0, 2);
        tv[15] = mk(4'b0000, 2'b00, 2'b11, 0, 4'b0000, 2'b11, 4, 4, 1, 0, 0);
        tv[16] = mk(4'b0000, 2'b11, 2'b00, 0, 4'b0000, 2'b11, 4, 4, 1, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst fifo_flush_", 64'(bus.fifo_flush_), 64'd1);
        chk("rst fifo_we_", 64'(bus.fifo_we_), 64'b11);
        chk("rst fifo_wd", bus.fifo_wd[0] | bus.fifo_wd[1], 64'd0);
        chk("rst flush_done", 64'(bus.flush_done), 64'd0);
        chk("rst count", 64'(bus.count), 64'd0);
        chk("rst empty", 64'(bus.empty), 64'd1);
        chk("rst full", 64'(bus.full), 64'd0);
        chk("rst req_rdy", 64'(bus.req_rdy), 64'd0);
        reset_ = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].re, tv[i].fv, tv[i].fr);
            #1;
            chk_vec(i, tv[i]);
        end

        // Fill to DEPTH-1 one write per cycle; last grant to req3 leaves rr at 0.
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            drive(4'b1000, 2'b11, 2'b00, 1'b0);
            #1;
            chk($sformatf("fill%0d count", c), 64'(bus.count), 64'(c));
            chk($sformatf("fill%0d req_rdy", c), 64'(bus.req_rdy), 64'b1000);
        end

        @(negedge clk);
        drive(4'b0011, 2'b11, 2'b00, 1'b0);
        #1;
        chk("nearfull count", 64'(bus.count), 64'd31);
        chk("nearfull req_rdy", 64'(bus.req_rdy), 64'b0001);
        chk("nearfull fifo_we_", 64'(bus.fifo_we_), 64'b10);
        chk("nearfull wd0", bus.fifo_wd[0], pay(0));

        @(negedge clk);
        drive(4'b1111, 2'b11, 2'b00, 1'b0);
        #1;
        chk("full count", 64'(bus.count), 64'd32);
        chk("full flag", 64'(bus.full), 64'd1);
        chk("full empty", 64'(bus.empty), 64'd0);
        chk("full req_rdy", 64'(bus.req_rdy), 64'd0);
        chk("full fifo_we_", 64'(bus.fifo_we_), 64'b11);

        @(negedge clk);
        drive(4'b0001, 2'b10, 2'b01, 1'b0);
        #1;
        chk("pop samecycle req_rdy", 64'(bus.req_rdy), 64'd0);
        chk("pop count", 64'(bus.count), 64'd32);

        @(negedge clk);
        drive(4'b0001, 2'b11, 2'b00, 1'b0);
        #1;
        chk("afterpop count", 64'(bus.count), 64'd31);
        chk("afterpop req_rdy", 64'(bus.req_rdy), 64'b0001);
        chk("afterpop fifo_we_", 64'(bus.fifo_we_), 64'b10);

        @(negedge clk);
        drive(4'b0000, 2'b11, 2'b00, 1'b0);
        #1;
        chk("refill count", 64'(bus.count), 64'd32);
        chk("refill full", 64'(bus.full), 64'd1);

        // Flush interrupted by an asynchronous reset while in FLUSH.
        @(negedge clk);
        drive(4'b0000, 2'b11, 2'b00, 1'b1);
        #1;
        chk("fr idle fifo_flush_", 64'(bus.fifo_flush_), 64'd1);
        @(negedge clk);
        #1;
        chk("fr flush fifo_flush_", 64'(bus.fifo_flush_), 64'd0);
        #2;
        reset_ = 1'b0;
        #1;
        chk("midrst fifo_flush_", 64'(bus.fifo_flush_), 64'd1);
        chk("midrst count", 64'(bus.count), 64'd0);
        chk("midrst flush_done", 64'(bus.flush_done), 64'd0);
        chk("midrst empty", 64'(bus.empty), 64'd1);
        @(negedge clk);
        reset_ = 1'b1;
        drive(4'b0011, 2'b11, 2'b00, 1'b0);
        #1;
        chk("postrst req_rdy", 64'(bus.req_rdy), 64'b0011);
        chk("postrst wd0", bus.fifo_wd[0], pay(0));
        chk("postrst wd1", bus.fifo_wd[1], pay(1));
        @(negedge clk);
        drive(4'b0000, 2'b11, 2'b00, 1'b0);
        #1;
        chk("postrst flush_done", 64'(bus.flush_done), 64'd0);
        chk("postrst count", 64'(bus.count), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
